tcls_recovery_sequencer: RTL and testbench
==========================================

TCLS_RECOVERY_SEQUENCER -- requirements
Module: tcls_recovery_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BaseAddr, 32'h0, register-block base address.
- Mm0Offset, 32'h4, MISMATCHES_0 offset; MISMATCHES_1 and MISMATCHES_2 at +4 and +8.
- SpStoreOffset, 32'h10, SP_STORE offset.
- SpSetValue, 32'h1, nonzero value written to SP_STORE.
- HoldCycles, 16, cycles between SP_STORE set and clear (>=1).
- TimeoutCycles, 256, maximum wait for reg_ready_i (>=2).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; synchronous, active-high.
- mismatch_i, in, 1, triple-core mismatch indication from the lock-step unit.
- err_clr_i, in, 1, clears err_o.
- reg_valid_o, out, 1, register request valid.
- reg_write_o, out, 1, 1 = write.
- reg_addr_o, out, 32, request address.
- reg_wdata_o, out, 32, write data.
- reg_wstrb_o, out, 4, write strobe.
- reg_ready_i, in, 1, responder ready.
- reg_rdata_i, in, 32, read data.
- reg_error_i, in, 1, response error.
- busy_o, out, 1, sequence in progress.
- done_o, out, 1, one-cycle pulse on successful completion.
- err_o, out, 1, sticky abort flag.
- mm_cnt_o, out, 3x32, last captured MISMATCHES_0..2.
- faulty_core_o, out, 3, one-hot/multi-hot set of counters that changed in the last sequence.

REQ-003 The block SHALL be the register-bus initiator for the lock-step manager registers, with a single clock clk_i and a synchronous active-high reset rst_i.

Function
REQ-004 A transfer SHALL complete in the cycle where reg_valid_o && reg_ready_i; the request fields SHALL be held stable while reg_valid_o=1 and not ready.
REQ-005 The FSM states SHALL be IDLE, RD0, RD1, RD2, SET, HOLD, CLR, DONE and ABORT.
REQ-006 In IDLE, mismatch_i=1 (or the pending flag set) SHALL move to RD0 next cycle; reg_valid_o SHALL rise in the first RD0 cycle.
REQ-007 RD0/RD1/RD2 SHALL issue reads with reg_write_o=0 to BaseAddr+Mm0Offset, +4 and +8 respectively; on completion without error, reg_rdata_i SHALL be captured into mm_cnt_o[n] and the FSM SHALL advance.
REQ-008 After RD2 completes, faulty_core_o[n] SHALL be set to (new mm_cnt_o[n] != previous mm_cnt_o[n]).
REQ-009 SET SHALL write SpSetValue to BaseAddr+SpStoreOffset with wstrb=4'hF; CLR SHALL write 32'h0 to the same address with wstrb=4'hF.
REQ-010 HOLD SHALL last exactly HoldCycles cycles with reg_valid_o=0, counted by a down-counter.
REQ-011 DONE SHALL last one cycle with done_o=1, then the FSM SHALL return to IDLE.
REQ-012 reg_error_i=1 on any completing transfer SHALL go to ABORT; rdata SHALL NOT be captured on an errored read.
REQ-013 A wait counter SHALL reset at each request start; reg_valid_o held TimeoutCycles cycles without ready SHALL go to ABORT with reg_valid_o dropped.
REQ-014 ABORT SHALL last one cycle, set err_o, clear the pending flag, then return to IDLE.
REQ-015 err_o SHALL stay set until err_clr_i=1; if abort and clear occur in the same cycle, set SHALL win.
REQ-016 mismatch_i=1 while busy SHALL set a single pending flag (further events coalesce); the pending flag SHALL be consumed on entry to RD0 from IDLE.
REQ-017 mismatch_i=1 in the DONE cycle SHALL set pending, causing a new sequence right after IDLE.
REQ-018 busy_o SHALL be 1 in every state except IDLE.
REQ-019 When reg_valid_o=0, reg_addr_o, reg_wdata_o and reg_wstrb_o SHALL be 0.
REQ-020 The counter comparison in REQ-008 SHALL be 32-bit inequality; counter wrap-around SHALL be treated as a change.

Reset
REQ-021 rst_i=1 at a clock edge SHALL force state=IDLE and all outputs to 0, including mm_cnt_o, faulty_core_o, err_o, pending and all counters.
REQ-022 Reset mid-transfer SHALL drop reg_valid_o in the next cycle, with no completion and no SP_STORE clear issued.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Mismatch pulse, ready always 1, rdata {5,3,3} after a prior {3,3,3} -> reads 0x4/0x8/0xC, write 0x10=1, HoldCycles idle, write 0x10=0, done_o pulse; faulty_core_o=3'b001.
- Ready delayed 3 cycles on RD1 -> request fields stable 4 cycles, sequence completes normally.
- Ready never asserted on SET -> reg_valid_o drops after 256 cycles; err_o=1 until err_clr_i.
- reg_error_i on RD2 -> ABORT, mm_cnt_o[2] unchanged, no SP_STORE writes.
- Three mismatch pulses during HOLD -> exactly one additional sequence after done_o.
- rst_i during HOLD -> all outputs 0 next cycle, no CLR write.

Source files
------------

// File: rtl/tcls_recovery_sequencer.sv
// Lock-step recovery initiator: on mismatch, reads MISMATCHES_0..2, sets SP_STORE, waits HoldCycles, clears SP_STORE.
// One request at a time with fields held while stalled; a request stalled for TimeoutCycles or errored aborts the sequence.
module tcls_recovery_sequencer #(
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [31:0] Mm0Offset     = 32'h4,
    parameter logic [31:0] SpStoreOffset = 32'h10,
    parameter logic [31:0] SpSetValue    = 32'h1,
    parameter int unsigned HoldCycles    = 16,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mismatch_i,
    input  logic             err_clr_i,
    output logic             reg_valid_o,
    output logic             reg_write_o,
    output logic [31:0]      reg_addr_o,
    output logic [31:0]      reg_wdata_o,
    output logic [3:0]       reg_wstrb_o,
    input  logic             reg_ready_i,
    input  logic [31:0]      reg_rdata_i,
    input  logic             reg_error_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0][31:0] mm_cnt_o,
    output logic [2:0]       faulty_core_o
);
    localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam int unsigned WaitW = $clog2(TimeoutCycles);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_SET, S_HOLD, S_CLR, S_DONE, S_ABORT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pending;
    logic             r_err;
    logic [2:0][31:0] r_mm_cnt;
    logic [2:0]       r_faulty;
    logic [1:0]       r_chg;
    logic [HoldW-1:0] r_hold_cnt;
    logic [WaitW-1:0] r_wait_cnt;

    logic             w_req;
    logic             w_write;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_wstrb;
    logic             w_xfer;
    logic             w_ok;
    logic             w_timeout;

    always_comb begin
        w_req   = 1'b0;
        w_write = 1'b0;
        w_addr  = 32'h0;
        w_wdata = 32'h0;
        w_wstrb = 4'h0;
        case (r_state)
            S_RD0: begin w_req = 1'b1; w_addr = BaseAddr + Mm0Offset;         end
            S_RD1: begin w_req = 1'b1; w_addr = BaseAddr + Mm0Offset + 32'd4; end
            S_RD2: begin w_req = 1'b1; w_addr = BaseAddr + Mm0Offset + 32'd8; end
            S_SET: begin
                w_req   = 1'b1;
                w_write = 1'b1;
                w_addr  = BaseAddr + SpStoreOffset;
                w_wdata = SpSetValue;
                w_wstrb = 4'hF;
            end
            S_CLR: begin
                w_req   = 1'b1;
                w_write = 1'b1;
                w_addr  = BaseAddr + SpStoreOffset;
                w_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    assign w_xfer    = w_req && reg_ready_i;
    assign w_ok      = w_xfer && !reg_error_i;
    assign w_timeout = w_req && !reg_ready_i && (r_wait_cnt == WaitW'(TimeoutCycles - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (mismatch_i || r_pending) w_state_nxt = S_RD0;
            S_RD0:   if (w_ok) w_state_nxt = S_RD1;
            S_RD1:   if (w_ok) w_state_nxt = S_RD2;
            S_RD2:   if (w_ok) w_state_nxt = S_SET;
            S_SET:   if (w_ok) w_state_nxt = S_HOLD;
            S_HOLD:  if (r_hold_cnt == '0) w_state_nxt = S_CLR;
            S_CLR:   if (w_ok) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if ((w_xfer && reg_error_i) || w_timeout) w_state_nxt = S_ABORT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_mm_cnt   <= '0;
            r_faulty   <= 3'b000;
            r_chg      <= 2'b00;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Leaving IDLE consumes any pending event; ABORT discards it.
            if (r_state == S_IDLE || r_state == S_ABORT) r_pending <= 1'b0;
            else if (mismatch_i)                         r_pending <= 1'b1;
            if (r_state == S_ABORT) r_err <= 1'b1;
            else if (err_clr_i)     r_err <= 1'b0;
            if (w_ok) begin
                case (r_state)
                    S_RD0: begin
                        r_mm_cnt[0] <= reg_rdata_i;
                        r_chg[0]    <= (reg_rdata_i != r_mm_cnt[0]);
                    end
                    S_RD1: begin
                        r_mm_cnt[1] <= reg_rdata_i;
                        r_chg[1]    <= (reg_rdata_i != r_mm_cnt[1]);
                    end
                    S_RD2: begin
                        r_mm_cnt[2] <= reg_rdata_i;
                        r_faulty    <= {(reg_rdata_i != r_mm_cnt[2]), r_chg};
                    end
                    default: ;
                endcase
            end
            if (r_state == S_SET)                          r_hold_cnt <= HoldW'(HoldCycles - 1);
            else if (r_state == S_HOLD && r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
            if (!w_req || w_xfer) r_wait_cnt <= '0;
            else                  r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign reg_valid_o   = w_req;
    assign reg_write_o   = w_write;
    assign reg_addr_o    = w_addr;
    assign reg_wdata_o   = w_wdata;
    assign reg_wstrb_o   = w_wstrb;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign err_o         = r_err;
    assign mm_cnt_o      = r_mm_cnt;
    assign faulty_core_o = r_faulty;

endmodule

// File: tb/tb_tcls_recovery_sequencer.sv
// Directed bench for tcls_recovery_sequencer: bench-driven responder, transfer log, hand-computed expectations.
module tb_tcls_recovery_sequencer;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_i;
    logic             mismatch_i;
    logic             err_clr_i;
    logic             reg_valid_o;
    logic             reg_write_o;
    logic [31:0]      reg_addr_o;
    logic [31:0]      reg_wdata_o;
    logic [3:0]       reg_wstrb_o;
    logic             reg_ready_i;
    logic [31:0]      reg_rdata_i;
    logic             reg_error_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [2:0][31:0] mm_cnt_o;
    logic [2:0]       faulty_core_o;

    logic [31:0] rd_tab0, rd_tab1, rd_tab2, err_addr;
    logic        err_on;

    assign reg_rdata_i = (reg_addr_o == 32'h4) ? rd_tab0 :
                         (reg_addr_o == 32'h8) ? rd_tab1 :
                         (reg_addr_o == 32'hC) ? rd_tab2 : 32'h0;
    assign reg_error_i = err_on && reg_valid_o && (reg_addr_o == err_addr);

    tcls_recovery_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mismatch_i   (mismatch_i),
        .err_clr_i    (err_clr_i),
        .reg_valid_o  (reg_valid_o),
        .reg_write_o  (reg_write_o),
        .reg_addr_o   (reg_addr_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_wstrb_o  (reg_wstrb_o),
        .reg_ready_i  (reg_ready_i),
        .reg_rdata_i  (reg_rdata_i),
        .reg_error_i  (reg_error_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .mm_cnt_o     (mm_cnt_o),
        .faulty_core_o(faulty_core_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Transfer log and event counters, sampled mid-cycle.
    logic        log_wr    [0:63];
    logic [31:0] log_addr  [0:63];
    logic [31:0] log_wdata [0:63];
    logic [3:0]  log_wstrb [0:63];
    int n_log = 0, n_wr = 0, n_done = 0, n_gap = 0, n_rd1 = 0, n_set = 0, n_unstable = 0;
    logic        prev_stall = 1'b0;
    logic [68:0] prev_req   = '0;

    always @(negedge clk_i) begin
        if (reg_valid_o && reg_ready_i) begin
            if (n_log < 64) begin
                log_wr[n_log]    = reg_write_o;
                log_addr[n_log]  = reg_addr_o;
                log_wdata[n_log] = reg_wdata_o;
                log_wstrb[n_log] = reg_wstrb_o;
            end
            n_log++;
            if (reg_write_o) n_wr++;
        end
        if (done_o) n_done++;
        if (busy_o && !reg_valid_o && !done_o) n_gap++;
        if (reg_valid_o && reg_addr_o == 32'h8) n_rd1++;
        if (reg_valid_o && reg_write_o && reg_wdata_o == 32'h1) n_set++;
        if (prev_stall && reg_valid_o &&
            {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o} != prev_req) n_unstable++;
        prev_stall = reg_valid_o && !reg_ready_i;
        prev_req   = {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o};
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_mm();
        mismatch_i = 1'b1;
        step();
        mismatch_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy_o && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(busy_o), 32'h0);
    endtask

    task automatic wait_hold(input string tag);
        for (int k = 0; k < 20 && !(busy_o && !reg_valid_o); k++) step();
        check(tag, 32'(busy_o && !reg_valid_o), 32'h1);
    endtask

    initial begin
        int b, db, gb, rb, ub, sb, wb;
        rst_i = 1'b1; mismatch_i = 1'b0; err_clr_i = 1'b0; reg_ready_i = 1'b1;
        rd_tab0 = 32'd3; rd_tab1 = 32'd3; rd_tab2 = 32'd3; err_on = 1'b0; err_addr = 32'h0;
        step(); step();
        check("rst_valid",  32'(reg_valid_o),   32'h0);
        check("rst_busy",   32'(busy_o),        32'h0);
        check("rst_err",    32'(err_o),         32'h0);
        check("rst_addr",   reg_addr_o,         32'h0);
        check("rst_faulty", 32'(faulty_core_o), 32'h0);
        rst_i = 1'b0;
        step();

        // Prime counters to {3,3,3}: all three differ from reset zeros.
        pulse_mm();
        check("s0_first_vld",  32'(reg_valid_o), 32'h1);
        check("s0_first_addr", reg_addr_o,       32'h4);
        wait_idle(100, "s0_idle");
        check("s0_faulty", 32'(faulty_core_o), 32'h7);
        check("s0_mm1",    mm_cnt_o[1],        32'd3);

        // Normal sequence, counters {5,3,3}.
        rd_tab0 = 32'd5;
        b = n_log; db = n_done; gb = n_gap;
        pulse_mm();
        wait_idle(100, "s1_idle");
        check("s1_nxfer",  n_log - b,           32'd5);
        check("s1_addr0",  log_addr[b],         32'h4);
        check("s1_wr0",    32'(log_wr[b]),      32'h0);
        check("s1_addr1",  log_addr[b+1],       32'h8);
        check("s1_addr2",  log_addr[b+2],       32'hC);
        check("s1_set_a",  log_addr[b+3],       32'h10);
        check("s1_set_w",  32'(log_wr[b+3]),    32'h1);
        check("s1_set_d",  log_wdata[b+3],      32'h1);
        check("s1_clr_a",  log_addr[b+4],       32'h10);
        check("s1_clr_d",  log_wdata[b+4],      32'h0);
        check("s1_clr_s",  32'(log_wstrb[b+4]), 32'hF);
        check("s1_done",   n_done - db,         32'd1);
        check("s1_hold",   n_gap - gb,          32'd16);
        check("s1_faulty", 32'(faulty_core_o),  32'h1);
        check("s1_mm0",    mm_cnt_o[0],         32'd5);

        // RD1 stalled 3 cycles.
        rb = n_rd1; ub = n_unstable; db = n_done;
        pulse_mm();
        for (int k = 0; k < 20 && reg_addr_o != 32'h8; k++) step();
        check("s2_rd1_reached", reg_addr_o, 32'h8);
        reg_ready_i = 1'b0;
        step(); step(); step();
        reg_ready_i = 1'b1;
        wait_idle(100, "s2_idle");
        check("s2_rd1_cycles", n_rd1 - rb,          32'd4);
        check("s2_stable",     n_unstable - ub,     32'd0);
        check("s2_done",       n_done - db,         32'd1);
        check("s2_faulty",     32'(faulty_core_o),  32'h0);

        // SET never acknowledged: timeout abort.
        sb = n_set; wb = n_wr; db = n_done;
        pulse_mm();
        for (int k = 0; k < 20 && !reg_write_o; k++) step();
        check("s3_set_reached", 32'(reg_write_o), 32'h1);
        reg_ready_i = 1'b0;
        wait_idle(400, "s3_idle");
        reg_ready_i = 1'b1;
        check("s3_set_cycles", n_set - sb,   32'd256);
        check("s3_no_write",   n_wr - wb,    32'd0);
        check("s3_no_done",    n_done - db,  32'd0);
        check("s3_err",        32'(err_o),   32'h1);
        step(); step(); step();
        check("s3_err_sticky", 32'(err_o), 32'h1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("s3_err_clr", 32'(err_o), 32'h0);

        // Error response on RD2.
        rd_tab0 = 32'd7; rd_tab1 = 32'd9; rd_tab2 = 32'd11;
        err_on = 1'b1; err_addr = 32'hC;
        wb = n_wr;
        pulse_mm();
        wait_idle(100, "s4_idle");
        err_on = 1'b0;
        check("s4_err",      32'(err_o),         32'h1);
        check("s4_mm0",      mm_cnt_o[0],        32'd7);
        check("s4_mm1",      mm_cnt_o[1],        32'd9);
        check("s4_mm2",      mm_cnt_o[2],        32'd3);
        check("s4_no_write", n_wr - wb,          32'd0);
        check("s4_faulty",   32'(faulty_core_o), 32'h0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("s4_err_clr", 32'(err_o), 32'h0);

        // Three mismatches during HOLD coalesce into one extra sequence.
        db = n_done; wb = n_wr;
        pulse_mm();
        wait_hold("s5_hold");
        for (int i = 0; i < 3; i++) begin
            pulse_mm();
            step();
        end
        for (int i = 0; i < 80; i++) step();
        check("s5_done",   n_done - db,        32'd2);
        check("s5_writes", n_wr - wb,          32'd4);
        check("s5_busy",   32'(busy_o),        32'h0);
        check("s5_faulty", 32'(faulty_core_o), 32'h0);
        check("s5_mm2",    mm_cnt_o[2],        32'd11);

        // Reset during HOLD.
        wb = n_wr;
        pulse_mm();
        wait_hold("s6_hold");
        step(); step();
        rst_i = 1'b1;
        step();
        check("s6_busy",  32'(busy_o),      32'h0);
        check("s6_valid", 32'(reg_valid_o), 32'h0);
        check("s6_done",  32'(done_o),      32'h0);
        check("s6_mm0",   mm_cnt_o[0],      32'h0);
        check("s6_mm2",   mm_cnt_o[2],      32'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("s6_no_clr",   n_wr - wb,   32'd1);
        check("s6_idle",     32'(busy_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
